// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Operands are scanned MSB-first, DIGIT bits
// per clock, and the scan stops at the first digit where A and B differ.
// Two's-complement operands are mapped to offset binary at capture time by
// flipping their sign bits, so the scan itself is always unsigned.
//
// Parameters:
//   WIDTH  operand width; a multiple of DIGIT and at least DIGIT
//   DIGIT  bits compared per clock
//   CW     width of cycles (derived, leave at its default)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      compare request, only looked at while idle
//   a, b       operands, captured when start is accepted
//   is_signed  1 = two's-complement compare, captured with the operands
//   busy       high while a scan is running
//   done       one-cycle pulse; lt/eq/gt/cycles valid from this cycle on
//   lt/eq/gt   result of the last compare (all 0 until the first one)
//   cycles     digits examined by the last compare (1..WIDTH/DIGIT)
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter int CW    = $clog2(WIDTH / DIGIT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [CW-1:0]    cycles
);

  localparam int NDIG = WIDTH / DIGIT;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, a_sh_nxt, b_sh_nxt;
  logic [CW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [CW-1:0]    cycles_nxt;
  logic             busy_nxt, done_nxt, lt_nxt, eq_nxt, gt_nxt;
  logic [DIGIT-1:0] dig_a, dig_b;

  // The operand registers are shifted left after every equal digit, so the
  // digit under test is always the top DIGIT bits. This keeps a fixed-position
  // DIGIT-wide compare on the critical path instead of an idx-driven mux.
  assign dig_a = a_sh[WIDTH-1 -: DIGIT];
  assign dig_b = b_sh[WIDTH-1 -: DIGIT];

  // Next-state and next-output logic. Everything holds by default and done
  // drops back to 0, which is what makes done a single-cycle pulse.
  always_comb begin
    state_nxt  = state;
    a_sh_nxt   = a_sh;
    b_sh_nxt   = b_sh;
    idx_nxt    = idx;
    count_nxt  = count;
    cycles_nxt = cycles;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    lt_nxt     = lt;
    eq_nxt     = eq;
    gt_nxt     = gt;

    case (state)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit turns two's-complement order into unsigned
          // order, so signed and unsigned compares share the same scan.
          a_sh_nxt            = a;
          b_sh_nxt            = b;
          a_sh_nxt[WIDTH-1]   = a[WIDTH-1] ^ is_signed;
          b_sh_nxt[WIDTH-1]   = b[WIDTH-1] ^ is_signed;
          idx_nxt             = CW'(NDIG - 1);
          count_nxt           = '0;
          busy_nxt            = 1'b1;
          state_nxt           = SCAN;
        end
      end

      SCAN: begin
        if (dig_a != dig_b) begin
          gt_nxt     = (dig_a > dig_b);
          lt_nxt     = !(dig_a > dig_b);
          eq_nxt     = 1'b0;
          cycles_nxt = count + CW'(1);
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else if (idx == '0) begin
          gt_nxt     = 1'b0;
          lt_nxt     = 1'b0;
          eq_nxt     = 1'b1;
          cycles_nxt = CW'(NDIG);
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          state_nxt  = IDLE;
        end else begin
          a_sh_nxt  = a_sh << DIGIT;
          b_sh_nxt  = b_sh << DIGIT;
          idx_nxt   = idx - CW'(1);
          count_nxt = count + CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and result registers. Reset aborts an in-flight scan without a done
  // pulse and takes priority over a start seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      idx    <= '0;
      count  <= '0;
      cycles <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lt     <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_sh   <= a_sh_nxt;
      b_sh   <= b_sh_nxt;
      idx    <= idx_nxt;
      count  <= count_nxt;
      cycles <= cycles_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      lt     <= lt_nxt;
      eq     <= eq_nxt;
      gt     <= gt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//
// Drives three comparator instances (16/4, 8/1, 32/8) from one clock and
// reset, and checks results, digit counts and latency against a reference
// model that works on whole integer values.
// Unit index: 0 = WIDTH16/DIGIT4, 1 = WIDTH8/DIGIT1, 2 = WIDTH32/DIGIT8.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v, sgn_v, busy_v, done_v, lt_v, eq_v, gt_v;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic [2:0]  cyc16;
  logic [3:0]  cyc8;
  logic [2:0]  cyc32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a16), .b(b16),
    .is_signed(sgn_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .lt(lt_v[0]), .eq(eq_v[0]), .gt(gt_v[0]), .cycles(cyc16)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a8), .b(b8),
    .is_signed(sgn_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .lt(lt_v[1]), .eq(eq_v[1]), .gt(gt_v[1]), .cycles(cyc8)
  );

  seq_magnitude_comparator #(.WIDTH(32), .DIGIT(8)) dut32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a32), .b(b32),
    .is_signed(sgn_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .lt(lt_v[2]), .eq(eq_v[2]), .gt(gt_v[2]), .cycles(cyc32)
  );

  // Global watchdog so the run always ends even if something stalls badly.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int widthOf(input int u);
    return (u == 0) ? 16 : (u == 1) ? 8 : 32;
  endfunction

  function automatic int digitOf(input int u);
    return (u == 0) ? 4 : (u == 1) ? 1 : 8;
  endfunction

  function automatic logic [31:0] cycOf(input int u);
    case (u)
      0:       return 32'(cyc16);
      1:       return 32'(cyc8);
      default: return 32'(cyc32);
    endcase
  endfunction

  // Reference: order by integer value, digit count from the highest bit
  // where the operands differ.
  task automatic refModel(input int w, input int d, input logic [31:0] a,
                          input logic [31:0] b, input bit sgn,
                          output bit rlt, output bit req, output bit rgt,
                          output int rcyc);
    longint va, vb;
    logic [31:0] x;
    int msb;
    va = longint'(a);
    vb = longint'(b);
    if (sgn && a[w-1]) va = va - (longint'(1) << w);
    if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
    rlt = (va < vb);
    req = (va == vb);
    rgt = (va > vb);
    x   = a ^ b;
    msb = -1;
    for (int i = 0; i < w; i++) if (x[i]) msb = i;
    rcyc = (msb < 0) ? (w / d) : ((w - 1 - msb) / d + 1);
  endtask

  task automatic applyStimulus(input int u, input logic [31:0] a,
                               input logic [31:0] b, input bit sgn,
                               input bit st);
    case (u)
      0:       begin a16 = a[15:0]; b16 = b[15:0]; end
      1:       begin a8  = a[7:0];  b8  = b[7:0];  end
      default: begin a32 = a;       b32 = b;       end
    endcase
    sgn_v[u]   = sgn;
    start_v[u] = st;
  endtask

  // Called at a negedge inside the scan; returns at the negedge where done
  // is seen, with the number of busy cycles observed on the way.
  task automatic waitForDone(input int u, output int busy_cnt);
    int n;
    busy_cnt = 0;
    n = 0;
    while (!done_v[u] && n < LIMIT) begin
      if (busy_v[u]) busy_cnt++;
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 32'(done_v[u]), 32'd1);
  endtask

  task automatic checkResult(input string tag, input int u,
                             input logic [31:0] a, input logic [31:0] b,
                             input bit sgn);
    bit rlt, req, rgt;
    int rcyc;
    refModel(widthOf(u), digitOf(u), a, b, sgn, rlt, req, rgt, rcyc);
    checkOutput({tag, "_lt"},  32'(lt_v[u]), 32'(rlt));
    checkOutput({tag, "_eq"},  32'(eq_v[u]), 32'(req));
    checkOutput({tag, "_gt"},  32'(gt_v[u]), 32'(rgt));
    checkOutput({tag, "_cyc"}, cycOf(u),     32'(rcyc));
    checkOutput({tag, "_busy_at_done"}, 32'(busy_v[u]), 32'd0);
  endtask

  // Full transaction: one-cycle start pulse, operands scrambled right after
  // capture, then result and latency checked.
  task automatic runCompare(input string tag, input int u,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit sgn);
    int bc, rcyc;
    bit rlt, req, rgt;
    refModel(widthOf(u), digitOf(u), a, b, sgn, rlt, req, rgt, rcyc);
    applyStimulus(u, a, b, sgn, 1'b1);
    @(negedge clk);
    applyStimulus(u, ~a, ~b, ~sgn, 1'b0);
    waitForDone(u, bc);
    checkOutput({tag, "_latency"}, 32'(bc), 32'(rcyc));
    checkResult(tag, u, a, b, sgn);
  endtask

  initial begin
    int bc;
    int seen;
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [31:0] ra, rb, mask;
    bit rs;

    rst     = 1'b1;
    start_v = '0;
    sgn_v   = '0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);

    for (int u = 0; u < 3; u++) begin
      checkOutput("rst_busy", 32'(busy_v[u]), 32'd0);
      checkOutput("rst_done", 32'(done_v[u]), 32'd0);
      checkOutput("rst_flags", 32'({lt_v[u], eq_v[u], gt_v[u]}), 32'd0);
      checkOutput("rst_cyc", cycOf(u), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_flags", 32'({lt_v[0], eq_v[0], gt_v[0]}), 32'd0);

    // Directed cases on the 16/4 unit.
    runCompare("equal", 0, 32'h1234, 32'h1234, 1'b0);
    checkOutput("equal_eq_const", 32'(eq_v[0]), 32'd1);
    checkOutput("equal_cyc_const", cycOf(0), 32'd4);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done_v[0]), 32'd0);
    checkOutput("result_hold", 32'(eq_v[0]), 32'd1);

    runCompare("early_u", 0, 32'h8000, 32'h0001, 1'b0);
    checkOutput("early_u_gt_const", 32'(gt_v[0]), 32'd1);
    runCompare("early_s", 0, 32'h8000, 32'h0001, 1'b1);
    checkOutput("early_s_lt_const", 32'(lt_v[0]), 32'd1);
    checkOutput("early_s_cyc_const", cycOf(0), 32'd1);
    runCompare("mid_u", 0, 32'h12F0, 32'h12E0, 1'b0);
    checkOutput("mid_u_cyc_const", cycOf(0), 32'd3);
    runCompare("neg_s", 0, 32'hFFFF, 32'hFFFE, 1'b1);
    checkOutput("neg_s_gt_const", 32'(gt_v[0]), 32'd1);
    checkOutput("neg_s_cyc_const", cycOf(0), 32'd4);

    // Start held high: each done must be followed by busy the next cycle.
    pa = '{32'h1234, 32'hA000, 32'h0010, 32'h7FFF};
    pb = '{32'h1234, 32'h0FFF, 32'h0011, 32'h7FFE};
    applyStimulus(0, pa[0], pb[0], 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("b2b_busy", 32'(busy_v[0]), 32'd1);
      checkOutput("b2b_nodone", 32'(done_v[0]), 32'd0);
      waitForDone(0, bc);
      checkResult("b2b", 0, pa[i], pb[i], 1'b0);
      if (i < 3) applyStimulus(0, pa[i+1], pb[i+1], 1'b0, 1'b1);
      else       applyStimulus(0, pa[i], pb[i], 1'b0, 1'b0);
    end

    // A start pulse mid-scan with other operands must be ignored.
    applyStimulus(0, 32'h1234, 32'h1239, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 32'hFFFF, 32'h0000, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(0, 32'h0000, 32'hFFFF, 1'b0, 1'b0);
    waitForDone(0, bc);
    checkOutput("ignored_latency", 32'(bc + 1), 32'd4);
    checkResult("ignored", 0, 32'h1234, 32'h1239, 1'b0);

    // Reset in the second scan cycle aborts without a done pulse.
    applyStimulus(0, 32'h1234, 32'h1234, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(0, 32'h1234, 32'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("abort_done", 32'(done_v[0]), 32'd0);
    checkOutput("abort_flags", 32'({lt_v[0], eq_v[0], gt_v[0]}), 32'd0);
    checkOutput("abort_cyc", cycOf(0), 32'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen++;
    end
    checkOutput("abort_quiet", 32'(seen), 32'd0);
    runCompare("after_abort", 0, 32'h0F00, 32'h0F01, 1'b1);

    // Reset and start together: reset wins.
    applyStimulus(0, 32'h1111, 32'h2222, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 32'h1111, 32'h2222, 1'b0, 1'b0);
    checkOutput("rst_start_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    checkOutput("rst_start_idle", 32'(busy_v[0]), 32'd0);

    // Random sweep on all three geometries, biased toward equal and
    // single-bit-different operand pairs.
    for (int u = 0; u < 3; u++) begin
      mask = (widthOf(u) == 32) ? 32'hFFFF_FFFF
                                : ((32'd1 << widthOf(u)) - 32'd1);
      for (int i = 0; i < 40; i++) begin
        ra = $urandom & mask;
        case ($urandom_range(3, 0))
          0:       rb = ra;
          1:       rb = (ra ^ (32'd1 << $urandom_range(widthOf(u) - 1, 0))) & mask;
          default: rb = $urandom & mask;
        endcase
        rs = 1'($urandom_range(1, 0));
        runCompare("rand", u, ra, rb, rs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator that generalises the team's combinational 4-bit lt/eq/gt comparator to any width. It scans operands MSB-first, DIGIT bits per clock, and stops early at the first differing digit. It supports unsigned and two's-complement modes, selected per transaction. It sits behind register-mapped operand latches and uses a start/busy/done handshake, so it can replace wide combinational comparators on timing-critical paths.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
DIGIT, 4, bits compared per clock; NDIG = WIDTH/DIGIT digits per operand.
CW, $clog2(NDIG)+1, width of the cycles output (derived; not to be overridden).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request a compare; sampled only in IDLE.
a  in  WIDTH  operand A, captured on an accepted start.
b  in  WIDTH  operand B, captured on an accepted start.
is_signed  in  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
busy  out  1  high while a scan is in progress.
done  out  1  one-cycle pulse; results are valid from this cycle onward.
lt  out  1  A < B.
eq  out  1  A == B.
gt  out  1  A > B.
cycles  out  CW  number of digits examined in the last compare (1..NDIG).

Behaviour:
- Only one clock and one reset. Reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, lt, eq, gt = 0; cycles = 0; operand registers and index = 0.
- FSM has two states, IDLE and SCAN.
- IDLE and start=1:
  - capture a, b and is_signed;
  - if is_signed=1, invert bit WIDTH-1 of both captured operands (offset-binary mapping), so the scan always does an unsigned compare;
  - set idx = NDIG-1 and a per-transaction count = 0;
  - go to SCAN with busy=1 on the next edge.
- IDLE and start=0: hold everything; lt/eq/gt/cycles keep the last result.
- SCAN, each cycle: compare digit idx of A' and B' (bits idx*DIGIT+DIGIT-1 .. idx*DIGIT).
  - Digits differ: on the next edge register gt = (digitA > digitB), lt = the inverse, eq = 0, cycles = count+1, done=1, busy=0, state -> IDLE.
  - Digits equal and idx==0: on the next edge register eq=1, lt=gt=0, cycles=NDIG, done=1, busy=0, state -> IDLE.
  - Digits equal and idx>0: decrement idx, increment count, stay in SCAN.
- Latency: start accepted at edge N, so done is high in the cycle after edge N+k, where k = digits examined (1..NDIG). Best case is 1 compare cycle; worst case (equal, or differing only in the LSB digit) is NDIG.
- done is high for exactly one cycle, and the FSM is already in IDLE during it. A start in the done cycle is accepted, giving back-to-back operation with no bubble.
- lt/eq/gt change only together with a done pulse. After the first done, exactly one of them is 1. Before the first done (and after reset) all three are 0.
- start while busy=1 is ignored: no capture, the in-flight scan is unaffected, and no error is flagged. The caller must wait for done.
- a, b and is_signed may change freely after the capture edge.
- rst during SCAN aborts on that edge: no done pulse, and all outputs return to their reset values.
- rst and start in the same cycle: rst wins and the start is dropped.
- Arithmetic: no adders on the compare path; digit comparison is a DIGIT-wide magnitude compare. The idx and count counters are CW bits wide and never wrap, because the scan stops at idx==0.

Test Plan:
- Equal operands, WIDTH=16, DIGIT=4: a=0x1234, b=0x1234, is_signed=0, start pulse -> busy for 4 cycles, then done with eq=1, lt=gt=0, cycles=4.
- Early exit: a=0x8000, b=0x0001, unsigned -> done after 1 compare cycle, gt=1, cycles=1. Same operands with is_signed=1 -> lt=1, cycles=1.
- Mid-word difference and negative values: a=0x12F0, b=0x12E0 unsigned -> gt=1, cycles=3. Signed a=0xFFFF (-1) vs b=0xFFFE (-2) -> gt=1, cycles=4.
- Back-to-back and ignored start: start held high continuously with alternating operand pairs -> each done is followed next cycle by busy=1. A start pulse mid-scan with different operands -> no effect on the current result.
- Reset mid-operation: assert rst in the 2nd SCAN cycle of a 4-digit compare -> next cycle busy=done=lt=eq=gt=0, cycles=0, no done pulse. A fresh compare afterwards completes correctly.
- Parameter sweep: WIDTH=8/DIGIT=1 and WIDTH=32/DIGIT=8 with random signed and unsigned operands, checked against a reference model for both result and cycles count.
